// File: rtl/lineoblique.sv
// Bresenham line-point generator: walks from (x_offset,y_offset) to (x_final,y_final)
// and emits one pixel per clock on Xline/Yline. curseur flags each valid pixel, and
// red/green/blue are white while it is high.
// Ports:
//   clk, reset                  - clock and asynchronous active-low reset
//   x_offset/y_offset           - start point
//   x_final/y_final             - end point
//   red/green/blue              - 0xFF while a pixel is emitted, else 0
//   Xline/Yline                 - current pixel (equal to x_step/y_step)
//   x_step/y_step               - working coordinate registers
//   x_step_next/y_step_next     - combinational value of x_step/y_step after the next edge
//   Xcount/Ycount               - X/Y moves taken since the line started
//   delta_x/delta_y             - absolute deltas of the latched line
//   error/error2                - Bresenham error and its double, low EW bits
//   droit/bas                   - X/Y direction flags (1 = increasing)
//   x_period/y_period           - current DRAW cycle moves X/Y (combinational)
//   start_mark                  - pulse on the first DRAW cycle
//   done_mark                   - high while the line is complete
//   curseur                     - high on every DRAW cycle
module lineoblique #(
    parameter int unsigned XW = 11,
    parameter int unsigned YW = 10,
    parameter int unsigned EW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [XW-1:0] x_offset,
    input  logic [YW-1:0] y_offset,
    input  logic [XW-1:0] x_final,
    input  logic [YW-1:0] y_final,
    output logic [7:0]    red,
    output logic [7:0]    green,
    output logic [7:0]    blue,
    output logic [XW-1:0] Xline,
    output logic [YW-1:0] Yline,
    output logic [XW-1:0] x_step,
    output logic [YW-1:0] y_step,
    output logic [XW-1:0] x_step_next,
    output logic [YW-1:0] y_step_next,
    output logic [XW-1:0] Xcount,
    output logic [YW-1:0] Ycount,
    output logic [EW-1:0] delta_x,
    output logic [EW-1:0] delta_y,
    output logic [EW-1:0] error,
    output logic [EW-1:0] error2,
    output logic          droit,
    output logic          bas,
    output logic          x_period,
    output logic          y_period,
    output logic          start_mark,
    output logic          done_mark,
    output logic          curseur
);

    // Internal signed arithmetic width; holds 2*err for the largest deltas.
    localparam int unsigned IW = 14;
    localparam logic [7:0] WHITE = 8'hFF;

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

    state_t               state, state_d;
    logic [XW-1:0]        xo_q, xf_q, xo_d, xf_d;
    logic [YW-1:0]        yo_q, yf_q, yo_d, yf_d;
    logic [XW-1:0]        x_step_d, xcount_d;
    logic [YW-1:0]        y_step_d, ycount_d;
    logic signed [IW-1:0] dx_q, dy_q, err_q, dx_d, dy_d, err_d;
    logic signed [IW-1:0] ddx, ddy, adx, ady, e2;
    logic                 droit_d, bas_d;
    logic                 x_mv, y_mv, at_end, ends_changed;
    logic                 curseur_d, start_d, done_d;

    // Next-state and datapath next values.
    always_comb begin
        state_d  = state;
        xo_d     = xo_q;
        yo_d     = yo_q;
        xf_d     = xf_q;
        yf_d     = yf_q;
        x_step_d = x_step;
        y_step_d = y_step;
        xcount_d = Xcount;
        ycount_d = Ycount;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        droit_d  = droit;
        bas_d    = bas;
        x_mv     = 1'b0;
        y_mv     = 1'b0;

        ddx          = $signed(IW'(x_final)) - $signed(IW'(x_offset));
        ddy          = $signed(IW'(y_final)) - $signed(IW'(y_offset));
        adx          = ddx[IW-1] ? -ddx : ddx;
        ady          = ddy[IW-1] ? -ddy : ddy;
        e2           = err_q <<< 1;
        at_end       = (x_step == xf_q) && (y_step == yf_q);
        ends_changed = (x_offset != xo_q) || (y_offset != yo_q) ||
                       (x_final != xf_q) || (y_final != yf_q);

        case (state)
            IDLE: state_d = LOAD;
            LOAD: begin
                xo_d     = x_offset;
                yo_d     = y_offset;
                xf_d     = x_final;
                yf_d     = y_final;
                dx_d     = adx;
                dy_d     = ady;
                droit_d  = !ddx[IW-1];
                bas_d    = !ddy[IW-1];
                x_step_d = x_offset;
                y_step_d = y_offset;
                xcount_d = '0;
                ycount_d = '0;
                err_d    = adx - ady;
                state_d  = DRAW;
            end
            DRAW: begin
                if (at_end) begin
                    state_d = DONE;
                end else begin
                    x_mv = (e2 > -dy_q);
                    y_mv = (e2 < dx_q);
                    if (x_mv) begin
                        err_d    = err_q - dy_q;
                        x_step_d = droit ? x_step + XW'(1) : x_step - XW'(1);
                        xcount_d = Xcount + XW'(1);
                    end
                    if (y_mv) begin
                        err_d    = err_d + dx_q;
                        y_step_d = bas ? y_step + YW'(1) : y_step - YW'(1);
                        ycount_d = Ycount + YW'(1);
                    end
                end
            end
            DONE: if (ends_changed) state_d = LOAD;
            default: state_d = IDLE;
        endcase

        // Pixel flags are registered from the upcoming state so they align with it.
        curseur_d = (state_d == DRAW);
        start_d   = (state == LOAD);
        done_d    = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            xo_q       <= '0;
            yo_q       <= '0;
            xf_q       <= '0;
            yf_q       <= '0;
            x_step     <= '0;
            y_step     <= '0;
            Xcount     <= '0;
            Ycount     <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            err_q      <= '0;
            droit      <= 1'b0;
            bas        <= 1'b0;
            curseur    <= 1'b0;
            start_mark <= 1'b0;
            done_mark  <= 1'b0;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
        end else begin
            state      <= state_d;
            xo_q       <= xo_d;
            yo_q       <= yo_d;
            xf_q       <= xf_d;
            yf_q       <= yf_d;
            x_step     <= x_step_d;
            y_step     <= y_step_d;
            Xcount     <= xcount_d;
            Ycount     <= ycount_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            err_q      <= err_d;
            droit      <= droit_d;
            bas        <= bas_d;
            curseur    <= curseur_d;
            start_mark <= start_d;
            done_mark  <= done_d;
            red        <= curseur_d ? WHITE : 8'h00;
            green      <= curseur_d ? WHITE : 8'h00;
            blue       <= curseur_d ? WHITE : 8'h00;
        end
    end

    assign Xline       = x_step;
    assign Yline       = y_step;
    assign x_step_next = x_step_d;
    assign y_step_next = y_step_d;
    assign x_period    = x_mv;
    assign y_period    = y_mv;
    assign delta_x     = dx_q[EW-1:0];
    assign delta_y     = dy_q[EW-1:0];
    assign error       = err_q[EW-1:0];
    assign error2      = e2[EW-1:0];

endmodule

// File: tb/tb_lineoblique.sv
// Self-checking bench for lineoblique: a plain integer Bresenham walk builds the
// expected pixel list for each line and every DRAW/DONE cycle is compared against it.
module tb_lineoblique;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x_offset, x_final;
    logic [9:0]  y_offset, y_final;
    logic [7:0]  red, green, blue;
    logic [10:0] Xline, x_step, x_step_next, Xcount;
    logic [9:0]  Yline, y_step, y_step_next, Ycount;
    logic [11:0] delta_x, delta_y, error, error2;
    logic        droit, bas, x_period, y_period, start_mark, done_mark, curseur;

    typedef struct {
        int x;
        int y;
        int err;
        bit mx;
        bit my;
    } pix_t;

    pix_t exp_q[$];
    int   m_dx, m_dy;
    bit   m_droit, m_bas;
    int   checks = 0;
    int   errors = 0;

    lineoblique dut (
        .clk(clk), .reset(reset),
        .x_offset(x_offset), .y_offset(y_offset), .x_final(x_final), .y_final(y_final),
        .red(red), .green(green), .blue(blue),
        .Xline(Xline), .Yline(Yline), .x_step(x_step), .y_step(y_step),
        .x_step_next(x_step_next), .y_step_next(y_step_next),
        .Xcount(Xcount), .Ycount(Ycount), .delta_x(delta_x), .delta_y(delta_y),
        .error(error), .error2(error2), .droit(droit), .bas(bas),
        .x_period(x_period), .y_period(y_period), .start_mark(start_mark),
        .done_mark(done_mark), .curseur(curseur)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Integer Bresenham walk: one entry per emitted pixel.
    task automatic build_model(input int xo, input int yo, input int xf, input int yf);
        int x, y, err, e2, sx, sy, guard;
        pix_t p;
        exp_q.delete();
        m_droit = (xf >= xo);
        m_bas   = (yf >= yo);
        m_dx    = m_droit ? xf - xo : xo - xf;
        m_dy    = m_bas ? yf - yo : yo - yf;
        sx      = m_droit ? 1 : -1;
        sy      = m_bas ? 1 : -1;
        x = xo; y = yo; err = m_dx - m_dy; guard = 0;
        while (guard < 4100) begin
            p.x = x; p.y = y; p.err = err;
            if (x == xf && y == yf) begin
                p.mx = 1'b0; p.my = 1'b0;
                exp_q.push_back(p);
                break;
            end
            e2   = 2 * err;
            p.mx = (e2 > -m_dy);
            p.my = (e2 < m_dx);
            exp_q.push_back(p);
            if (p.mx) begin err -= m_dy; x += sx; end
            if (p.my) begin err += m_dx; y += sy; end
            guard++;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_Xline"}, int'(Xline), 0);
        chk({tag, "_Yline"}, int'(Yline), 0);
        chk({tag, "_Xcount"}, int'(Xcount), 0);
        chk({tag, "_Ycount"}, int'(Ycount), 0);
        chk({tag, "_curseur"}, int'(curseur), 0);
        chk({tag, "_start"}, int'(start_mark), 0);
        chk({tag, "_done"}, int'(done_mark), 0);
        chk({tag, "_red"}, int'(red), 0);
        chk({tag, "_delta_x"}, int'(delta_x), 0);
        chk({tag, "_error"}, int'(error), 0);
        chk({tag, "_droit"}, int'(droit), 0);
        chk({tag, "_xnext"}, int'(x_step_next), 0);
    endtask

    // Drives one line and checks every DRAW cycle and the first DONE cycle.
    task automatic run_line(input int xo, input int yo, input int xf, input int yf,
                            input bit glitch, input int abort_at);
        int   n, cx, cy, mx_run;
        pix_t nxt;
        build_model(xo, yo, xf, yf);
        mx_run = (m_dx > m_dy) ? m_dx : m_dy;
        chk("model_len_rule", exp_q.size(), mx_run + 1);
        x_offset = 11'(xo); y_offset = 10'(yo);
        x_final  = 11'(xf); y_final  = 10'(yf);
        n = 0;
        while (start_mark !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", int'(start_mark), 1);
        if (start_mark !== 1'b1) return;
        cx = 0; cy = 0;
        foreach (exp_q[i]) begin
            if (i == abort_at) begin
                reset = 1'b0;
                #1;
                check_zero("abort");
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            nxt = (i + 1 < exp_q.size()) ? exp_q[i+1] : exp_q[i];
            chk("curseur", int'(curseur), 1);
            chk("start_mark", int'(start_mark), (i == 0) ? 1 : 0);
            chk("done_mark", int'(done_mark), 0);
            chk("Xline", int'(Xline), exp_q[i].x);
            chk("Yline", int'(Yline), exp_q[i].y);
            chk("x_period", int'(x_period), int'(exp_q[i].mx));
            chk("y_period", int'(y_period), int'(exp_q[i].my));
            chk("x_step_next", int'(x_step_next), nxt.x);
            chk("y_step_next", int'(y_step_next), nxt.y);
            chk("Xcount", int'(Xcount), cx);
            chk("Ycount", int'(Ycount), cy);
            chk("error", int'(error), exp_q[i].err & 'hFFF);
            chk("error2", int'(error2), (2 * exp_q[i].err) & 'hFFF);
            chk("red", int'(red), 255);
            chk("green", int'(green), 255);
            chk("blue", int'(blue), 255);
            chk("delta_x", int'(delta_x), m_dx);
            chk("delta_y", int'(delta_y), m_dy);
            chk("droit", int'(droit), int'(m_droit));
            chk("bas", int'(bas), int'(m_bas));
            cx += int'(exp_q[i].mx);
            cy += int'(exp_q[i].my);
            if (glitch && i == 1) begin
                x_offset = 11'($urandom); y_offset = 10'($urandom);
                x_final  = 11'($urandom); y_final  = 10'($urandom);
            end
            if (glitch && i == 3) begin
                x_offset = 11'(xo); y_offset = 10'(yo);
                x_final  = 11'(xf); y_final  = 10'(yf);
            end
            @(negedge clk);
        end
        chk("done_done", int'(done_mark), 1);
        chk("done_curseur", int'(curseur), 0);
        chk("done_start", int'(start_mark), 0);
        chk("done_red", int'(red), 0);
        chk("done_Xline", int'(Xline), xf);
        chk("done_Yline", int'(Yline), yf);
        chk("done_Xcount", int'(Xcount), m_dx);
        chk("done_Ycount", int'(Ycount), m_dy);
        chk("done_xper", int'(x_period), 0);
    endtask

    initial begin
        int px, py, pfx, pfy, xo, yo, xf, yf, bx, by, len;
        reset = 1'b0;
        x_offset = 11'd0; y_offset = 10'd0; x_final = 11'd99; y_final = 10'd39;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        reset = 1'b1;

        run_line(0, 0, 99, 39, 1'b0, -1);
        chk("L1_len", exp_q.size(), 100);
        chk("L1_last_x", exp_q[$].x, 99);
        chk("L1_last_y", exp_q[$].y, 39);
        chk("L1_dut_Xcount", int'(Xcount), 99);
        chk("L1_dut_Ycount", int'(Ycount), 39);

        run_line(3, 0, 12, 4, 1'b0, -1);
        chk("L2_len", exp_q.size(), 10);
        chk("L2_dut_Ycount", int'(Ycount), 4);

        run_line(3, 0, 15, 4, 1'b0, -1);

        run_line(50, 40, 10, 0, 1'b0, -1);
        chk("L3_len", exp_q.size(), 41);
        chk("L3_dut_droit", int'(droit), 0);
        chk("L3_dut_bas", int'(bas), 0);
        chk("L3_diag", int'(exp_q[5].mx && exp_q[5].my), 1);

        run_line(5, 5, 7, 30, 1'b0, -1);
        chk("L4_len", exp_q.size(), 26);
        chk("L4_dut_Xcount", int'(Xcount), 2);

        run_line(20, 20, 20, 20, 1'b0, -1);
        chk("L5_len", exp_q.size(), 1);
        chk("L5_dut_Xcount", int'(Xcount), 0);

        run_line(0, 0, 2047, 1023, 1'b1, -1);
        run_line(2047, 1023, 0, 0, 1'b0, -1);

        run_line(100, 200, 300, 250, 1'b0, 5);
        run_line(100, 200, 300, 250, 1'b0, -1);

        px = 100; py = 200; pfx = 300; pfy = 250;
        for (int k = 0; k < 24; k++) begin
            do begin
                bx = int'($urandom_range(0, 1800));
                by = int'($urandom_range(0, 780));
                xo = bx + int'($urandom_range(0, 240));
                xf = bx + int'($urandom_range(0, 240));
                yo = by + int'($urandom_range(0, 240));
                yf = by + int'($urandom_range(0, 240));
                len = ((xf > xo) ? xf - xo : xo - xf);
                if (((yf > yo) ? yf - yo : yo - yf) > len) len = (yf > yo) ? yf - yo : yo - yf;
            end while ((xo == px && yo == py && xf == pfx && yf == pfy) || len < 5);
            run_line(xo, yo, xf, yf, k[0], -1);
            px = xo; py = yo; pfx = xf; pfy = yf;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
